// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU core.
// Holds the FSM state encoding, default datapath widths, the instruction
// field bit positions and the jump-condition helper.
package hack_pkg;

  localparam int HACK_DATA_W = 16;
  localparam int HACK_ADDR_W = 15;

  // Instruction field bit positions
  localparam int BIT_CI      = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int BIT_A       = 12;  // y operand select: 1 = M, 0 = A
  localparam int COMP_HI     = 11;  // comp field zx nx zy ny f no
  localparam int COMP_LO     = 6;
  localparam int DEST_A      = 5;
  localparam int DEST_D      = 4;
  localparam int DEST_M      = 3;
  localparam int JMP_LT      = 2;
  localparam int JMP_EQ      = 1;
  localparam int JMP_GT      = 0;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM_RD = 3'd2,
    EXEC   = 3'd3,
    MEM_WR = 3'd4
  } state_t;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr,
                                      input logic ng);
    return (j[JMP_LT] & ng) | (j[JMP_EQ] & zr) | (j[JMP_GT] & ~zr & ~ng);
  endfunction

endpackage

// File: rtl/hack_cpu_core_if.sv
// Instruction and data memory bus of the Hack CPU core.
// master: the core (drives req/addr/we/wdata, receives ack/rdata).
// slave : the memory system.
interface hack_cpu_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/hack_alu.sv
// Hack ALU, purely combinational.
// Ports: x, y operands; ctrl = {zx, nx, zy, ny, f, no};
//        out result, zr = (out == 0), ng = out negative.
module hack_alu #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic        [5:0]       ctrl,
  output logic signed [WIDTH-1:0] out,
  output logic                    zr,
  output logic                    ng
);
  logic signed [WIDTH-1:0] xa;
  logic signed [WIDTH-1:0] ya;
  logic signed [WIDTH-1:0] fo;

  always_comb begin
    xa = ctrl[5] ? '0 : x;
    if (ctrl[4]) xa = ~xa;
    ya = ctrl[3] ? '0 : y;
    if (ctrl[2]) ya = ~ya;
    fo = ctrl[1] ? (xa + ya) : (xa & ya);
    out = ctrl[0] ? ~fo : fo;
  end

  assign zr = (out == '0);
  assign ng = out[WIDTH-1];
endmodule

// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU core (FETCH, DECODE, MEM_RD, EXEC, MEM_WR).
// Ports: clk, rst_n (async active-low); bus = instruction/data memory
//        master; pc, a_reg, d_reg = architectural state for debug;
//        instr_done = one-cycle pulse after each instruction commit.
module hack_cpu_core
  import hack_pkg::*;
#(
  parameter int DATA_W = HACK_DATA_W,
  parameter int ADDR_W = HACK_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  hack_cpu_core_if.master     bus,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   a_reg,
  output logic [DATA_W-1:0]   d_reg,
  output logic                instr_done
);
  state_t state, state_nxt;

  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] m_reg;
  logic [DATA_W-1:0] out_q;
  logic              zr_q, ng_q;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zr, alu_ng;
  logic [DATA_W-1:0] res;
  logic              res_zr, res_ng;
  logic              commit, c_commit;
  logic              ir_unused;

  assign ir_unused = ^ir[14:13];

  hack_alu #(.WIDTH(DATA_W)) u_alu (
    .x    (d_reg),
    .y    (ir[BIT_A] ? m_reg : a_reg),
    .ctrl (ir[COMP_HI:COMP_LO]),
    .out  (alu_out),
    .zr   (alu_zr),
    .ng   (alu_ng)
  );

  // Commit from EXEC uses the live ALU result; from MEM_WR the latched one.
  assign res    = (state == EXEC) ? alu_out : out_q;
  assign res_zr = (state == EXEC) ? alu_zr  : zr_q;
  assign res_ng = (state == EXEC) ? alu_ng  : ng_q;

  // Requests are gated by rst_n so they drop the instant reset asserts.
  assign bus.imem_req   = rst_n && (state == FETCH);
  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = rst_n && ((state == MEM_RD) || (state == MEM_WR));
  assign bus.dmem_we    = rst_n && (state == MEM_WR);
  assign bus.dmem_addr  = a_reg[ADDR_W-1:0];
  assign bus.dmem_wdata = out_q;

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    c_commit  = 1'b0;
    case (state)
      FETCH:  if (bus.imem_ack) state_nxt = DECODE;
      DECODE: begin
        if (!ir[BIT_CI]) begin
          commit    = 1'b1;
          state_nxt = FETCH;
        end else if (ir[BIT_A]) begin
          state_nxt = MEM_RD;
        end else begin
          state_nxt = EXEC;
        end
      end
      MEM_RD: if (bus.dmem_ack) state_nxt = EXEC;
      EXEC: begin
        if (ir[DEST_M]) begin
          state_nxt = MEM_WR;
        end else begin
          commit    = 1'b1;
          c_commit  = 1'b1;
          state_nxt = FETCH;
        end
      end
      MEM_WR: begin
        if (bus.dmem_ack) begin
          commit    = 1'b1;
          c_commit  = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      ir         <= '0;
      m_reg      <= '0;
      out_q      <= '0;
      zr_q       <= 1'b0;
      ng_q       <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      instr_done <= commit;
      if ((state == FETCH) && bus.imem_ack) ir <= bus.imem_rdata;
      if ((state == MEM_RD) && bus.dmem_ack) m_reg <= bus.dmem_rdata;
      if (state == EXEC) begin
        out_q <= alu_out;
        zr_q  <= alu_zr;
        ng_q  <= alu_ng;
      end
      // Jump target reads a_reg before this same commit overwrites it.
      if (c_commit) begin
        if (ir[DEST_A]) a_reg <= res;
        if (ir[DEST_D]) d_reg <= res;
        pc <= jump_taken(ir[JMP_LT:JMP_GT], res_zr, res_ng)
              ? a_reg[ADDR_W-1:0] : pc + ADDR_W'(1);
      end else if (commit) begin
        a_reg <= DATA_W'(ir[14:0]);
        pc    <= pc + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hack_cpu_core.sv
module tb_hack_cpu_core;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] pc;
  logic [15:0] a_reg, d_reg;
  logic        instr_done;

  int vectors = 0;
  int miscompares = 0;
  int ddelay = 0;
  int dcnt = 0;
  int wr_cnt = 0;
  int wr0;
  logic [14:0] wr_addr = '0;
  logic [15:0] wr_data = '0;

  logic [15:0] imem [32];
  logic [15:0] dmem [16];

  always #5 clk = ~clk;

  hack_cpu_core_if #(.DATA_W(16), .ADDR_W(15)) bus ();

  hack_cpu_core #(.DATA_W(16), .ADDR_W(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.master),
    .pc         (pc),
    .a_reg      (a_reg),
    .d_reg      (d_reg),
    .instr_done (instr_done)
  );

  // Memory models: zero-wait instruction side, programmable data-side wait.
  assign bus.imem_ack   = bus.imem_req;
  assign bus.imem_rdata = imem[bus.imem_addr[4:0]];
  assign bus.dmem_ack   = bus.dmem_req && (dcnt >= ddelay);
  assign bus.dmem_rdata = dmem[bus.dmem_addr[3:0]];

  always_ff @(posedge clk) begin
    if (bus.dmem_req && !bus.dmem_ack) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (bus.dmem_req && bus.dmem_we && bus.dmem_ack) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.dmem_addr;
      wr_data <= bus.dmem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(1);
    for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) dmem[i] = 16'h0000;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) dmem[i] = 16'h0000;
    step(2);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_a", 32'(a_reg), 32'h0);
    chk("rst_d", 32'(d_reg), 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst_dmem_req", 32'(bus.dmem_req), 32'h0);
    chk("rst_dmem_we", 32'(bus.dmem_we), 32'h0);
    chk("rst_done", 32'(instr_done), 32'h0);

    // A-instruction, 2-cycle latency
    imem[0] = 16'h0005;
    rst_n = 1'b1;
    #1;
    chk("ainst_fetch_req", 32'(bus.imem_req), 32'h1);
    chk("ainst_fetch_addr", 32'(bus.imem_addr), 32'h0);
    step(1);
    chk("ainst_c1_done", 32'(instr_done), 32'h0);
    chk("ainst_c1_req", 32'(bus.imem_req), 32'h0);
    step(1);
    chk("ainst_a", 32'(a_reg), 32'h5);
    chk("ainst_pc", 32'(pc), 32'h1);
    chk("ainst_done", 32'(instr_done), 32'h1);
    step(1);
    chk("ainst_done_off", 32'(instr_done), 32'h0);

    // @5 D=A; M=D+1
    apply_reset();
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'hE7C8;
    wr0 = wr_cnt;
    rst_n = 1'b1;
    step(8);
    chk("mw_req", 32'(bus.dmem_req), 32'h1);
    chk("mw_we", 32'(bus.dmem_we), 32'h1);
    chk("mw_addr", 32'(bus.dmem_addr), 32'h5);
    chk("mw_wdata", 32'(bus.dmem_wdata), 32'h6);
    chk("mw_no_imem", 32'(bus.imem_req), 32'h0);
    chk("mw_d", 32'(d_reg), 32'h5);
    step(1);
    chk("mw_pc", 32'(pc), 32'h3);
    chk("mw_a", 32'(a_reg), 32'h5);
    chk("mw_cnt", 32'(wr_cnt - wr0), 32'h1);
    chk("mw_log_addr", 32'(wr_addr), 32'h5);
    chk("mw_log_data", 32'(wr_data), 32'h6);
    chk("mw_done", 32'(instr_done), 32'h1);

    // D=0: D;JEQ taken to 0x10
    apply_reset();
    imem[0] = 16'h0010; imem[1] = 16'hE302;
    rst_n = 1'b1;
    step(5);
    chk("jeq_taken_pc", 32'(pc), 32'h10);
    chk("jeq_taken_done", 32'(instr_done), 32'h1);

    // D=1: D;JEQ not taken
    apply_reset();
    imem[0] = 16'h0001; imem[1] = 16'hEC10; imem[2] = 16'h0010; imem[3] = 16'hE302;
    rst_n = 1'b1;
    step(10);
    chk("jeq_nt_pc", 32'(pc), 32'h4);
    chk("jeq_nt_d", 32'(d_reg), 32'h1);

    // A=D;JMP jumps to the old A
    apply_reset();
    imem[0] = 16'h0004; imem[1] = 16'hEC10; imem[2] = 16'h000C; imem[3] = 16'hE327;
    rst_n = 1'b1;
    step(10);
    chk("oldA_pc", 32'(pc), 32'hC);
    chk("oldA_a", 32'(a_reg), 32'h4);

    // D=M with 3 cycles of data wait
    apply_reset();
    ddelay = 3;
    imem[0] = 16'h0007; imem[1] = 16'hFC10; dmem[7] = 16'hBEEF;
    rst_n = 1'b1;
    step(3);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("mr_hold_req", 32'(bus.dmem_req), 32'h1);
      chk("mr_hold_addr", 32'(bus.dmem_addr), 32'h7);
      chk("mr_hold_we", 32'(bus.dmem_we), 32'h0);
      chk("mr_hold_nocommit", 32'(instr_done), 32'h0);
    end
    step(1);
    chk("mr_req_drop", 32'(bus.dmem_req), 32'h0);
    chk("mr_d_pre", 32'(d_reg), 32'h0);
    step(1);
    chk("mr_d", 32'(d_reg), 32'hBEEF);
    chk("mr_done", 32'(instr_done), 32'h1);
    chk("mr_pc", 32'(pc), 32'h2);

    // Reset during a stalled MEM_WR
    apply_reset();
    ddelay = 10;
    imem[0] = 16'hE7C8;
    wr0 = wr_cnt;
    rst_n = 1'b1;
    step(3);
    chk("rw_req", 32'(bus.dmem_req), 32'h1);
    chk("rw_we", 32'(bus.dmem_we), 32'h1);
    chk("rw_wdata", 32'(bus.dmem_wdata), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_req_async", 32'(bus.dmem_req), 32'h0);
    chk("rw_we_async", 32'(bus.dmem_we), 32'h0);
    chk("rw_a", 32'(a_reg), 32'h0);
    chk("rw_d", 32'(d_reg), 32'h0);
    chk("rw_pc", 32'(pc), 32'h0);
    chk("rw_no_write", 32'(wr_cnt - wr0), 32'h0);
    step(1);
    ddelay = 0;
    rst_n = 1'b1;
    #1;
    chk("rw_refetch_req", 32'(bus.imem_req), 32'h1);
    chk("rw_refetch_addr", 32'(bus.imem_addr), 32'h0);

    // pc wrap 0x7FFF -> 0x0000
    apply_reset();
    imem[0] = 16'h7FFF; imem[1] = 16'hEA87; imem[31] = 16'h0003;
    rst_n = 1'b1;
    step(5);
    chk("wrap_pc_top", 32'(pc), 32'h7FFF);
    chk("wrap_fetch_addr", 32'(bus.imem_addr), 32'h7FFF);
    step(2);
    chk("wrap_pc", 32'(pc), 32'h0);
    chk("wrap_a", 32'(a_reg), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hack_cpu_core.md
HACK_CPU_CORE -- requirements
Module: hack_cpu_core

Interface
REQ-001 Parameter DATA_W, default 16, data and register width.
REQ-002 Parameter ADDR_W, default 15, instruction and data address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req  output  1  instruction fetch request.
REQ-006 imem_addr  output  ADDR_W  fetch address (= pc).
REQ-007 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-008 imem_rdata  input  DATA_W  instruction word.
REQ-009 dmem_req  output  1  data memory request.
REQ-010 dmem_we  output  1  1 = write, 0 = read.
REQ-011 dmem_addr  output  ADDR_W  data address (= A[ADDR_W-1:0]).
REQ-012 dmem_wdata  output  DATA_W  write data.
REQ-013 dmem_ack  input  1  data access complete; dmem_rdata valid on reads.
REQ-014 dmem_rdata  input  DATA_W  read data.
REQ-015 pc, a_reg, d_reg  output  ADDR_W/DATA_W/DATA_W  architectural state, debug view.
REQ-016 instr_done  output  1  one-cycle pulse on every instruction commit.

Function
REQ-017 The FSM SHALL have states FETCH, DECODE, MEM_RD, EXEC and MEM_WR.
REQ-018 FETCH: imem_req=1 and imem_addr=pc; on imem_ack, IR<=imem_rdata, go to DECODE.
REQ-019 DECODE, IR[15]=0 (A-instruction): A<={0,IR[14:0]}, pc<=pc+1, commit, go to FETCH.
REQ-020 DECODE, C-instruction: if IR[12] (a bit)=1, go to MEM_RD; otherwise go to EXEC. IR[14:13] are ignored.
REQ-021 MEM_RD: dmem_req=1, dmem_we=0, dmem_addr=A; on dmem_ack, M_reg<=dmem_rdata, go to EXEC.
REQ-022 EXEC: ALU x=D, y=(a ? M_reg : A), control=IR[11:6]; latch out, zr and ng. If IR[3]=1, go to MEM_WR; otherwise commit and go to FETCH.
REQ-023 MEM_WR: dmem_req=1, dmem_we=1, dmem_addr=A (pre-commit value), dmem_wdata=latched out; on dmem_ack, commit and go to FETCH.
REQ-024 C commit, applied simultaneously:
- A<=out if IR[5].
- D<=out if IR[4].
- pc<=jump ? A_old[ADDR_W-1:0] : pc+1.
- jump=(IR[2]&ng)|(IR[1]&zr)|(IR[0]&~zr&~ng).
REQ-025 The jump target and the M address SHALL use A before the same instruction's A update.
REQ-026 Handshake timing:
- req, addr, we and wdata held stable until ack is sampled high.
- ack is honoured in any cycle req=1, including the first.
- req deasserts the cycle after ack.
- ack while req=0 is ignored.
REQ-027 instr_done SHALL pulse exactly one cycle per commit.
REQ-028 pc+1 SHALL wrap from 0x7FFF to 0x0000.
REQ-029 Zero-wait latencies: A-instruction 2 cycles; C without M access 3 cycles; C with M read or M write 4 cycles; both 5 cycles.
REQ-030 dmem_req and imem_req SHALL never be high in the same cycle.

Reset
REQ-031 On rst_n low, immediately:
- state=FETCH.
- pc, A, D, IR, M_reg and the latched ALU result/flags = 0.
- all req outputs and dmem_we = 0; instr_done = 0.
REQ-032 Reset during any pending transaction SHALL abandon it without commit.
REQ-033 After reset release, the first fetch SHALL be from address 0.

Structure
REQ-034 Package hack_pkg SHALL hold the FSM state enum, DATA_W/ADDR_W defaults and instruction field bit positions (a, comp, dest, jump).
REQ-035 The core SHALL instantiate the existing hack_alu (WIDTH=DATA_W) as its only sub-module.

Verification
REQ-036 Zero-wait, program @0 0x0005 (A-instruction): 2 cycles after reset release A=0x0005, pc=1, instr_done pulses once.
REQ-037 Program 0x0005, 0xEC10 (D=A), 0xE7C8 (M=D+1): MEM_WR with dmem_addr=5, dmem_wdata=6; D=5; pc=3.
REQ-038 D=0, A=0x0010, instruction 0xE302 (D;JEQ): pc=0x0010; repeat with D=1: pc=old pc+1.
REQ-039 0xFC10 (D=M) with dmem_ack delayed 3 cycles: dmem_req/addr held stable for 4 cycles; D=dmem_rdata; no commit before ack.
REQ-040 Assert rst_n during MEM_WR: dmem_req drops asynchronously, A/D unchanged at 0, next fetch at 0. Separately, pc=0x7FFF followed by an A-instruction gives pc=0x0000.
